// File: rtl/spi_pkg.sv
// Definitions shared by the SPI master, slave and sequencer: the default
// word width and the sequencer FSM state encoding.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_STORE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous first-word fall-through FIFO. Pushes into a full FIFO and pops
// from an empty one are ignored; a push and pop in the same cycle both apply.
module spi_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  push;
    logic                  pop;

    assign full_o    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o   = (count_q == '0);
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define valid entries.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/spi_master_seq.sv
// Host-side sequencer for an SPI master: TX FIFO -> launch -> wait -> RX FIFO.
// Define SPI_SEQ_TIMEOUT_EN to enable the WAIT watchdog and the err flag.
module spi_master_seq
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = SPI_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_m,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  start,
    output logic [DATA_WIDTH-1:0] data_in_master,
    input  logic                  finish,
    input  logic [DATA_WIDTH-1:0] data_out_master,
    output logic                  busy,
    output logic                  ovf,
    output logic                  err
);

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic                  ovf_q;
    logic                  tx_empty;
    logic                  tx_pop;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  rx_full;
    logic                  rx_push;
    logic                  to_hit;

    spi_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk_m),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .full_o    (full),
        .rd_en_i   (tx_pop),
        .rd_data_o (tx_head),
        .empty_o   (tx_empty)
    );

    spi_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk_m),
        .rst_n     (rst_n),
        .wr_en_i   (rx_push),
        .wr_data_i (cap_q),
        .full_o    (rx_full),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .empty_o   (empty)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q;
    logic          err_q;

    // A finish in the limit cycle takes priority over the abort.
    assign to_hit = (state_q == ST_WAIT) && !finish &&
                    (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_m or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == ST_WAIT && state_d == ST_WAIT) to_cnt_q <= to_cnt_q + 1'b1;
            else                                          to_cnt_q <= '0;
            if (to_hit) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign to_hit         = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        cap_d   = cap_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Launch only when the reply is guaranteed a slot in the RX FIFO.
                if (!tx_empty && !rx_full) begin
                    tx_pop  = 1'b1;
                    din_d   = tx_head;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (finish) begin
                    cap_d   = data_out_master;
                    state_d = ST_STORE;
                end else if (to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STORE: begin
                rx_push = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            din_q   <= '0;
            cap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            cap_q   <= cap_d;
            if (wr_en && full) ovf_q <= 1'b1;
        end
    end

    assign start          = (state_q == ST_LAUNCH);
    assign busy           = (state_q != ST_IDLE);
    assign data_in_master = din_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// Self-checking bench for spi_master_seq: vector table, directed corner cases
// and randomized traffic against a queue model. SPI_SEQ_TIMEOUT_EN adds watchdog cases.
module tb_spi_master_seq;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic          clk_m = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          finish = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] data_out_master = '0;
    logic          full, empty, start, busy, ovf, err;
    logic [DW-1:0] rd_data, data_in_master;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_start_q[$];
    logic [DW-1:0] exp_rx_q[$];
    logic [DW-1:0] host_q[$];

    typedef struct packed {
        logic [DW-1:0] tx;
        logic [DW-1:0] resp;
        logic [DW-1:0] exp_din;
        logic [DW-1:0] exp_rd;
    } vec_t;

    typedef struct {
        int            at;
        logic [DW-1:0] w;
    } land_t;

    vec_t          vecs[4];
    land_t         land_q[$];
    land_t         land_tmp;
    logic [DW-1:0] mtx_q[$];
    logic [DW-1:0] mrx_q[$];
    bit            m_ovf;
    bit            r_in_fl;
    bit            r_started;
    int            r_fin_cnt;
    logic [DW-1:0] r_resp;
    logic [DW-1:0] r_din;

    spi_master_seq #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_m           (clk_m),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .full            (full),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .empty           (empty),
        .start           (start),
        .data_in_master  (data_in_master),
        .finish          (finish),
        .data_out_master (data_out_master),
        .busy            (busy),
        .ovf             (ovf),
        .err             (err)
    );

    always #5 clk_m = ~clk_m;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_m);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_bit(name, start, 1'b0);
        end
    endtask

    // Feeds host_q, answers each start one cycle into WAIT with 0xA0+k,
    // optionally reads RX as words appear.
    task automatic serve(input int n, input int max_cyc, input bit auto_rd);
        int            seen = 0;
        int            last_fin = -10;
        bit            in_fl = 1'b0;
        bit            done = 1'b0;
        logic [DW-1:0] resp = '0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            if (host_q.size() > 0) begin
                wr_en   = 1'b1;
                wr_data = host_q.pop_front();
            end
            tick();
            wr_en  = 1'b0;
            finish = 1'b0;
            rd_en  = 1'b0;
            if (start) begin
                check_bit("serve_no_overlap", in_fl, 1'b0);
                if (exp_start_q.size() > 0)
                    check_word("serve_start_data", data_in_master, exp_start_q.pop_front());
                else
                    check_bit("serve_unexpected_start", start, 1'b0);
                seen++;
                in_fl = 1'b1;
                resp  = DW'(8'hA0 + seen);
            end else if (in_fl) begin
                check_bit("serve_busy_wait", busy, 1'b1);
                finish          = 1'b1;
                data_out_master = resp;
                exp_rx_q.push_back(resp);
                in_fl    = 1'b0;
                last_fin = c;
            end
            done = (seen >= n) && !in_fl && (c >= last_fin + 2) && (host_q.size() == 0);
            if (auto_rd && !done && !empty) begin
                if (exp_rx_q.size() > 0) begin
                    check_word("serve_rd_data", rd_data, exp_rx_q.pop_front());
                    rd_en = 1'b1;
                end else begin
                    check_bit("serve_rx_extra", empty, 1'b1);
                end
            end
        end
        check_int("serve_start_count", seen, n);
    endtask

    task automatic drain_rx(input int max_cyc);
        for (int c = 0; c < max_cyc && exp_rx_q.size() > 0; c++) begin
            if (!empty) begin
                check_word("drain_rd_data", rd_data, exp_rx_q.pop_front());
                rd_en = 1'b1;
            end
            tick();
            rd_en = 1'b0;
        end
        check_int("drain_left", exp_rx_q.size(), 0);
        check_bit("drain_empty", empty, 1'b1);
    endtask

    task automatic apply_reset();
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        finish = 1'b0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_start_q.delete();
        exp_rx_q.delete();
        host_q.delete();
    endtask

    initial begin
        vecs[0] = '{tx: 8'hB4, resp: 8'h55, exp_din: 8'hB4, exp_rd: 8'h55};
        vecs[1] = '{tx: 8'h00, resp: 8'hFF, exp_din: 8'h00, exp_rd: 8'hFF};
        vecs[2] = '{tx: 8'hFF, resp: 8'h00, exp_din: 8'hFF, exp_rd: 8'h00};
        vecs[3] = '{tx: 8'hA5, resp: 8'h5A, exp_din: 8'hA5, exp_rd: 8'h5A};

        // Reset state
        tick();
        check_bit("rst_start", start, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_full", full, 1'b0);
        check_bit("rst_empty", empty, 1'b1);
        check_bit("rst_ovf", ovf, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_word("rst_din", data_in_master, 8'h00);
        tick();
        rst_n = 1'b1;

        // Single transfers with exact latency; stray finish in IDLE and LAUNCH must be ignored
        for (int v = 0; v < 4; v++) begin
            wr_en           = 1'b1;
            wr_data         = vecs[v].tx;
            finish          = 1'b1;
            data_out_master = 8'hEE;
            tick();
            wr_en  = 1'b0;
            finish = 1'b0;
            check_bit("vec_start_n1", start, 1'b0);
            tick();
            check_bit("vec_start_n2", start, 1'b1);
            check_word("vec_din", data_in_master, vecs[v].exp_din);
            check_bit("vec_busy_launch", busy, 1'b1);
            finish          = 1'b1;
            data_out_master = 8'hEE;
            tick();
            finish = 1'b0;
            check_bit("vec_start_pulse", start, 1'b0);
            check_bit("vec_busy_wait", busy, 1'b1);
            finish          = 1'b1;
            data_out_master = vecs[v].resp;
            tick();
            finish = 1'b0;
            check_bit("vec_empty_m1", empty, 1'b1);
            check_word("vec_din_stable", data_in_master, vecs[v].exp_din);
            tick();
            check_bit("vec_empty_m2", empty, 1'b0);
            check_word("vec_rd_data", rd_data, vecs[v].exp_rd);
            check_bit("vec_busy_done", busy, 1'b0);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            check_bit("vec_empty_after_rd", empty, 1'b1);
        end

        // Back-to-back: four words, replies read afterwards in order
        host_q      = {8'h01, 8'h02, 8'h03, 8'h04};
        exp_start_q = {8'h01, 8'h02, 8'h03, 8'h04};
        serve(4, 80, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_bit("b2b_empty", empty, 1'b0);
            check_word("b2b_rd_data", rd_data, DW'(8'hA1 + i));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        check_bit("b2b_empty_end", empty, 1'b1);
        exp_rx_q.delete();

        // Overflow: a transfer parked in WAIT, then five writes
        push_word(8'hD0);
        tick();
        check_bit("ovf_launch", start, 1'b1);
        check_word("ovf_launch_din", data_in_master, 8'hD0);
        tick();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(8'h10 + i);
            tick();
            wr_en = 1'b0;
            check_bit("ovf_full", full, (i >= 3));
            check_bit("ovf_flag", ovf, (i == 4));
            check_bit("ovf_no_start", start, 1'b0);
        end
        finish          = 1'b1;
        data_out_master = 8'hE0;
        exp_rx_q        = {8'hE0};
        exp_start_q     = {8'h10, 8'h11, 8'h12, 8'h13};
        serve(4, 120, 1'b1);
        idle_check("ovf_dropped_word", 12);
        drain_rx(20);
        check_bit("ovf_sticky", ovf, 1'b1);

        // RX backpressure: RX full blocks the next launch until one read
        host_q      = {8'h41, 8'h42, 8'h43, 8'h44};
        exp_start_q = {8'h41, 8'h42, 8'h43, 8'h44};
        serve(4, 80, 1'b0);
        push_word(8'h77);
        exp_start_q.push_back(8'h77);
        for (int i = 0; i < 10; i++) begin
            check_bit("bp_no_start", start, 1'b0);
            check_bit("bp_idle", busy, 1'b0);
            tick();
        end
        check_word("bp_head", rd_data, exp_rx_q.pop_front());
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        serve(1, 20, 1'b0);
        drain_rx(30);

        // Reset while WAIT with 0x3C in flight
        push_word(8'h3C);
        tick();
        check_bit("rw_launch", start, 1'b1);
        check_word("rw_din", data_in_master, 8'h3C);
        tick();
        check_bit("rw_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("rw_start", start, 1'b0);
        check_bit("rw_busy0", busy, 1'b0);
        check_bit("rw_ovf", ovf, 1'b0);
        check_bit("rw_err", err, 1'b0);
        check_bit("rw_full", full, 1'b0);
        check_bit("rw_empty", empty, 1'b1);
        check_word("rw_din0", data_in_master, 8'h00);
        tick();
        rst_n           = 1'b1;
        finish          = 1'b1;
        data_out_master = 8'h3C;
        tick();
        finish = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_bit("rw_no_start", start, 1'b0);
            check_bit("rw_empty_after", empty, 1'b1);
            check_bit("rw_idle", busy, 1'b0);
            tick();
        end

`ifdef SPI_SEQ_TIMEOUT_EN
        // finish in the limit cycle wins over the abort
        push_word(8'h11);
        tick();
        check_bit("to_fw_launch", start, 1'b1);
        for (int k = 1; k <= TO; k++) begin
            tick();
            check_bit("to_fw_busy", busy, 1'b1);
            check_bit("to_fw_err", err, 1'b0);
            if (k == TO) begin
                finish          = 1'b1;
                data_out_master = 8'h99;
            end
        end
        tick();
        finish = 1'b0;
        check_bit("to_fw_err_after", err, 1'b0);
        check_bit("to_fw_store", busy, 1'b1);
        tick();
        check_bit("to_fw_empty", empty, 1'b0);
        check_word("to_fw_rd", rd_data, 8'h99);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;

        // No finish: abort after TO WAIT cycles
        push_word(8'h22);
        tick();
        check_bit("to_launch", start, 1'b1);
        for (int k = 1; k <= TO; k++) begin
            tick();
            check_bit("to_busy", busy, 1'b1);
            check_bit("to_err_pending", err, 1'b0);
        end
        tick();
        check_bit("to_err", err, 1'b1);
        check_bit("to_idle", busy, 1'b0);
        check_bit("to_empty", empty, 1'b1);
        host_q      = {8'h33};
        exp_start_q = {8'h33};
        serve(1, 20, 1'b0);
        drain_rx(10);
        check_bit("to_err_sticky", err, 1'b1);
`endif

        // Randomized traffic against the queue model
        apply_reset();
        m_ovf   = 1'b0;
        r_in_fl = 1'b0;
        r_din   = '0;
        for (int c = 0; c < 2400; c++) begin
            tick();
            wr_en  = 1'b0;
            rd_en  = 1'b0;
            finish = 1'b0;
            while (land_q.size() > 0 && land_q[0].at == c) begin
                land_tmp = land_q.pop_front();
                mrx_q.push_back(land_tmp.w);
            end
            r_started = start;
            if (start) begin
                check_bit("rnd_no_overlap", r_in_fl, 1'b0);
                check_bit("rnd_start_expected", (mtx_q.size() > 0), 1'b1);
                if (mtx_q.size() > 0) check_word("rnd_start_data", data_in_master, mtx_q.pop_front());
                r_din     = data_in_master;
                r_in_fl   = 1'b1;
                r_fin_cnt = $urandom_range(4, 1);
                r_resp    = DW'($urandom);
            end else if (r_in_fl) begin
                check_word("rnd_din_stable", data_in_master, r_din);
            end
            if (r_in_fl) check_bit("rnd_busy", busy, 1'b1);
            check_bit("rnd_full", full, (mtx_q.size() == DEPTH));
            check_bit("rnd_empty", empty, (mrx_q.size() == 0));
            if (mrx_q.size() > 0) check_word("rnd_rd_data", rd_data, mrx_q[0]);
            check_bit("rnd_ovf", ovf, m_ovf);

            if (r_in_fl && !r_started) begin
                r_fin_cnt--;
                if (r_fin_cnt == 0) begin
                    finish          = 1'b1;
                    data_out_master = r_resp;
                    land_q.push_back('{at: c + 2, w: r_resp});
                    r_in_fl = 1'b0;
                end
            end else if ((r_started || (!r_in_fl && land_q.size() == 0)) && $urandom_range(7, 0) == 0) begin
                finish          = 1'b1;
                data_out_master = DW'($urandom);
            end

            if (c < 2000) begin
                if ($urandom_range(99, 0) < 45) begin
                    wr_en   = 1'b1;
                    wr_data = DW'($urandom);
                    if (mtx_q.size() < DEPTH) mtx_q.push_back(wr_data);
                    else                      m_ovf = 1'b1;
                end
                rd_en = ($urandom_range(99, 0) < ((c < 1000) ? 25 : 60));
            end else begin
                rd_en = 1'b1;
            end
            if (rd_en && mrx_q.size() > 0) void'(mrx_q.pop_front());
        end
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        finish = 1'b0;
        check_int("rnd_tx_left", mtx_q.size(), 0);
        check_int("rnd_rx_left", mrx_q.size(), 0);
        check_int("rnd_land_left", land_q.size(), 0);
        check_bit("rnd_in_flight", r_in_fl, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
